// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder backing a 4 KB window at BASE_ADDR with NUM_REGS 32-bit registers.
// Define AXIL_SLV_ID_REG_EN to make register 0 a read-only ID register returning ID_VALUE.
module axi_lite_slave_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_REGS   = 16,
    parameter logic [31:0]           ID_VALUE   = 32'hA11E_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  reg_wr_pulse,
    output logic [9:0]            reg_wr_idx
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12]) && (32'(a[11:2]) < NUM_REGS);
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    w_state_t              r_wstate, w_wstate_n;
    logic                  r_awready, w_awready_n;
    logic                  r_wready, w_wready_n;
    logic                  r_bvalid, w_bvalid_n;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_n;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
    logic [3:0]            r_wstrb, w_wstrb_n;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_c_addr;
    logic [DATA_WIDTH-1:0] w_c_data;
    logic [3:0]            w_c_strb;
    logic [9:0]            w_c_idx;
    logic                  w_c_hit;
    logic                  r_wr_pulse;
    logic [9:0]            r_wr_idx;

    r_state_t              r_rstate, w_rstate_n;
    logic                  r_arready, w_arready_n;
    logic                  r_rvalid, w_rvalid_n;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
    logic [1:0]            r_rresp, w_rresp_n;
    logic [9:0]            w_rd_idx;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_val;

    wire w_aw_hs = awvalid & r_awready;
    wire w_w_hs  = wvalid & r_wready;
    wire w_ar_hs = arvalid & r_arready;
    wire w_unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign w_c_idx = w_c_addr[11:2];
`ifdef AXIL_SLV_ID_REG_EN
    assign w_c_hit = addr_hit(w_c_addr) && (w_c_idx != 10'd0);
`else
    assign w_c_hit = addr_hit(w_c_addr);
`endif

    always_comb begin
        w_wstate_n  = r_wstate;
        w_awready_n = r_awready;
        w_wready_n  = r_wready;
        w_bvalid_n  = r_bvalid;
        w_waddr_n   = r_waddr;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_commit    = 1'b0;
        w_c_addr    = r_waddr;
        w_c_data    = r_wdata;
        w_c_strb    = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                // Readies come up on the first edge out of reset.
                w_awready_n = 1'b1;
                w_wready_n  = 1'b1;
                if (w_aw_hs && w_w_hs) begin
                    w_commit    = 1'b1;
                    w_c_addr    = awaddr;
                    w_c_data    = wdata;
                    w_c_strb    = wstrb;
                    w_awready_n = 1'b0;
                    w_wready_n  = 1'b0;
                    w_wstate_n  = W_RESP;
                end else if (w_aw_hs) begin
                    w_waddr_n   = awaddr;
                    w_awready_n = 1'b0;
                    w_wstate_n  = W_WAIT_DATA;
                end else if (w_w_hs) begin
                    w_wdata_n  = wdata;
                    w_wstrb_n  = wstrb;
                    w_wready_n = 1'b0;
                    w_wstate_n = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: if (w_w_hs) begin
                w_commit   = 1'b1;
                w_c_data   = wdata;
                w_c_strb   = wstrb;
                w_wready_n = 1'b0;
                w_wstate_n = W_RESP;
            end
            W_WAIT_ADDR: if (w_aw_hs) begin
                w_commit    = 1'b1;
                w_c_addr    = awaddr;
                w_awready_n = 1'b0;
                w_wstate_n  = W_RESP;
            end
            W_RESP: if (r_bvalid && bready) begin
                w_bvalid_n  = 1'b0;
                w_awready_n = 1'b1;
                w_wready_n  = 1'b1;
                w_wstate_n  = W_IDLE;
            end
            default: w_wstate_n = W_IDLE;
        endcase
        if (w_commit) w_bvalid_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
            r_bvalid  <= w_bvalid_n;
            r_waddr   <= w_waddr_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            if (w_commit) r_bresp <= w_c_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_pulse <= w_commit && w_c_hit;
            if (w_commit && w_c_hit) r_wr_idx <= w_c_idx;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_c_hit && (w_c_idx == i[9:0])) begin
                    for (int b = 0; b < 4; b++)
                        if (w_c_strb[b]) r_regs[i][8*b +: 8] <= w_c_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_idx = araddr[11:2];
        w_rd_hit = addr_hit(araddr);
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_rd_idx == i[9:0]) w_rd_val = r_regs[i];
`ifdef AXIL_SLV_ID_REG_EN
        if (w_rd_idx == 10'd0) w_rd_val = ID_VALUE;
`endif
        if (!w_rd_hit) w_rd_val = '0;
    end

    always_comb begin
        w_rstate_n  = r_rstate;
        w_arready_n = r_arready;
        w_rvalid_n  = r_rvalid;
        w_rdata_n   = r_rdata;
        w_rresp_n   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                w_arready_n = 1'b1;
                if (w_ar_hs) begin
                    w_arready_n = 1'b0;
                    w_rvalid_n  = 1'b1;
                    w_rdata_n   = w_rd_val;
                    w_rresp_n   = w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                    w_rstate_n  = R_DATA;
                end
            end
            R_DATA: if (r_rvalid && rready) begin
                w_rvalid_n  = 1'b0;
                w_arready_n = 1'b1;
                w_rstate_n  = R_IDLE;
            end
            default: w_rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_n;
            r_arready <= w_arready_n;
            r_rvalid  <= w_rvalid_n;
            r_rdata   <= w_rdata_n;
            r_rresp   <= w_rresp_n;
        end
    end

    assign awready      = r_awready;
    assign wready       = r_wready;
    assign bvalid       = r_bvalid;
    assign bresp        = r_bresp;
    assign arready      = r_arready;
    assign rvalid       = r_rvalid;
    assign rdata        = r_rdata;
    assign rresp        = r_rresp;
    assign reg_wr_pulse = r_wr_pulse;
    assign reg_wr_idx   = r_wr_idx;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs (slot at 0x1000, 16 registers).
// Build with AXIL_SLV_ID_REG_EN defined to exercise the read-only ID register.
module tb_axi_lite_slave_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, reg_wr_pulse;
    logic [1:0]  bresp, rresp;
    logic [9:0]  reg_wr_idx;

    always #5 clk = ~clk;

    axi_lite_slave_regs #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_1000),
        .NUM_REGS(16), .ID_VALUE(32'hA11E_0001)
    ) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_wr_pulse(reg_wr_pulse), .reg_wr_idx(reg_wr_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  q_b[$];
    logic [33:0] q_r[$];
    logic [9:0]  q_p[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops expected responses whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (bvalid && bready) begin
                if (q_b.size() == 0) fail_now("unexpected write response");
                else check("bresp", 64'(bresp), 64'(q_b.pop_front()));
            end
            if (rvalid && rready) begin
                if (q_r.size() == 0) fail_now("unexpected read response");
                else check("rresp/rdata", 64'({rresp, rdata}), 64'(q_r.pop_front()));
            end
            if (reg_wr_pulse) begin
                if (q_p.size() == 0) fail_now("unexpected reg_wr_pulse");
                else check("reg_wr_idx", 64'(reg_wr_idx), 64'(q_p.pop_front()));
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit done = 0;
        awaddr = a; awvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (awready) done = 1;
        end
        if (!done) fail_now("awready timeout");
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (wready) done = 1;
        end
        if (!done) fail_now("wready timeout");
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done = 0;
        araddr = a; arvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (arready) done = 1;
        end
        if (!done) fail_now("arready timeout");
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid one cycle after AR", 64'(rvalid), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_b();
        bit seen = 0;
        bready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bvalid) seen = 1;
        end
        if (!seen) fail_now("bvalid timeout");
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wait_r();
        bit seen = 0;
        rready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rvalid) seen = 1;
        end
        if (!seen) fail_now("rvalid timeout");
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // pulse_idx < 0 means no register write is expected.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input int pulse_idx);
        q_b.push_back(exp_resp);
        if (pulse_idx >= 0) q_p.push_back(pulse_idx[9:0]);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
        q_r.push_back({exp_resp, exp_d});
        send_ar(a);
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset readies", 64'({awready, wready, arready}), 64'd0);
        check("reset valids", 64'({bvalid, rvalid, reg_wr_pulse}), 64'd0);
        check("reset data", 64'({bresp, rresp, rdata, reg_wr_idx}), 64'd0);
        @(negedge clk) reset = 1'b0;
        #1 check("awready before first edge", 64'(awready), 64'd0);
        @(posedge clk); #1;
        check("readies after first edge", 64'({awready, wready, arready}), 64'b111);

        // Combined AW+W write, then readback.
        do_write(32'h1004, 32'hDEADBEEF, 4'hF, 2'b00, 1);
        check("awready back after B handshake", 64'(awready), 64'd1);
        do_read(32'h1004, 32'hDEADBEEF, 2'b00);

        // AW first, W three cycles later.
        q_b.push_back(2'b00); q_p.push_back(10'd2);
        send_aw(32'h1008);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no bvalid before W", 64'(bvalid), 64'd0);
            check("awready low awaiting W", 64'({awready, wready}), 64'b01);
        end
        @(posedge clk); #1;
        send_w(32'h1234_5678, 4'hF);
        wait_b();
        do_read(32'h1008, 32'h1234_5678, 2'b00);

        // Byte strobes.
        do_write(32'h100C, 32'hFFFF_FFFF, 4'hF, 2'b00, 3);
        do_write(32'h100C, 32'hAABB_CCDD, 4'b0101, 2'b00, 3);
        do_read(32'h100C, 32'hFFBB_FFDD, 2'b00);

        // Decode: out of range index, other slots, ignored lsbs, last register.
        do_write(32'h1040, 32'h1111_1111, 4'hF, 2'b10, -1);
        do_write(32'h2004, 32'h2222_2222, 4'hF, 2'b10, -1);
        do_write(32'h0004, 32'h3333_3333, 4'hF, 2'b10, -1);
        do_read(32'h1040, 32'h0, 2'b10);
        do_read(32'h2004, 32'h0, 2'b10);
        do_read(32'h1006, 32'hDEADBEEF, 2'b00);
        do_write(32'h103C, 32'hC0FF_EE00, 4'hF, 2'b00, 15);
        do_read(32'h103F, 32'hC0FF_EE00, 2'b00);

        // W first, AW two cycles later.
        q_b.push_back(2'b00); q_p.push_back(10'd4);
        send_w(32'h1357_9BDF, 4'hF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("wready low awaiting AW", 64'({awready, wready, bvalid}), 64'b100);
        end
        @(posedge clk); #1;
        send_aw(32'h1010);
        wait_b();
        do_read(32'h1010, 32'h1357_9BDF, 2'b00);

        // Read and write to the same register on the same edge: read sees the old value.
        q_b.push_back(2'b00); q_p.push_back(10'd2); q_r.push_back({2'b00, 32'h1234_5678});
        fork
            send_aw(32'h1008);
            send_w(32'h55AA_55AA, 4'hF);
            send_ar(32'h1008);
        join
        fork
            wait_b();
            wait_r();
        join
        do_read(32'h1008, 32'h55AA_55AA, 2'b00);

`ifdef AXIL_SLV_ID_REG_EN
        do_read(32'h1000, 32'hA11E_0001, 2'b00);
        do_write(32'h1000, 32'h0000_0005, 4'hF, 2'b10, -1);
        do_read(32'h1000, 32'hA11E_0001, 2'b00);
`else
        do_write(32'h1000, 32'h0000_0005, 4'hF, 2'b00, 0);
        do_read(32'h1000, 32'h0000_0005, 2'b00);
`endif

        // Backpressure on both response channels.
        q_b.push_back(2'b00); q_p.push_back(10'd5); q_r.push_back({2'b00, 32'hDEADBEEF});
        fork
            send_aw(32'h1014);
            send_w(32'h0BAD_F00D, 4'hF);
            send_ar(32'h1004);
        join
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp bvalid/bresp", 64'({bvalid, bresp}), 64'b100);
            check("bp rvalid/rresp/rdata", 64'({rvalid, rresp, rdata}), {29'd0, 3'b100, 32'hDEADBEEF});
            check("bp readies low", 64'({awready, wready, arready}), 64'd0);
        end
        @(posedge clk); #1;
        fork
            wait_b();
            wait_r();
        join
        do_read(32'h1014, 32'h0BAD_F00D, 2'b00);

        // Reset while a read response is pending; the response is dropped.
        send_ar(32'h1014);
        reset = 1'b1;
        #1;
        check("rvalid cleared by reset", 64'(rvalid), 64'd0);
        check("outputs cleared by reset", 64'({arready, awready, bvalid, rdata}), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
`ifdef AXIL_SLV_ID_REG_EN
            do_read(32'h1000 + 32'(4 * i), (i == 0) ? 32'hA11E_0001 : 32'h0, 2'b00);
`else
            do_read(32'h1000 + 32'(4 * i), 32'h0, 2'b00);
`endif
        end

        repeat (2) @(posedge clk);
        check("write responses outstanding", 64'(q_b.size()), 64'd0);
        check("read responses outstanding", 64'(q_r.size()), 64'd0);
        check("write pulses outstanding", 64'(q_p.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder (slave) that pairs with our axi_lite_master-style initiators.
- Decodes a 4 KB window at BASE_ADDR and backs it with NUM_REGS 32-bit read/write registers.
- Write and read channels run as independent FSMs; one outstanding transaction per direction.
- Instantiated once per slave slot behind the interconnect (slave 0 at 0x0000_0000, slave 1 at 0x0000_1000).

Parameters:
- ADDR_WIDTH, 32, address width; must be >= 13.
- DATA_WIDTH, 32, data width; fixed at 32 (wstrb is 4 bits).
- BASE_ADDR, 32'h0000_0000, window base; bits [11:0] must be zero.
- NUM_REGS, 16, number of implemented registers, 1..1024.
- ID_VALUE, 32'hA11E_0001, constant returned by register 0 when AXIL_SLV_ID_REG_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  4  byte enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- reg_wr_pulse  out  1  one-cycle strobe on each committed register write.
- reg_wr_idx  out  10  index of the register written; valid while reg_wr_pulse is high.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset). All outputs and all registers are 0 during reset. Ready signals are registered and rise on the first clk edge after reset deasserts.
- Decode:
  - Hit when addr[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12] and idx = addr[11:2] < NUM_REGS.
  - addr[1:0] are ignored.
  - Hit gives resp OKAY (2'b00). Miss gives SLVERR (2'b10).
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W both handshake in the same cycle: commit the write, drive bvalid=1 with bresp, drop both readies, go to W_RESP.
    - AW only: latch the address, awready<=0, go to W_WAIT_DATA.
    - W only: latch wdata/wstrb, wready<=0, go to W_WAIT_ADDR.
  - W_WAIT_DATA / W_WAIT_ADDR: wait for the missing beat, then commit and go to W_RESP.
  - Commit:
    - On a hit, each byte lane i updates only if wstrb[i]=1.
    - reg_wr_pulse=1 for one cycle on the commit cycle, with reg_wr_idx=idx.
    - A miss changes no register and produces no pulse.
  - W_RESP: hold bvalid and bresp stable until bready. On the bvalid&bready cycle: bvalid<=0, awready<=1, wready<=1, go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1.
    - On arvalid: arready<=0, rvalid<=1, rdata<=reg[idx] (0 on a miss), rresp as decoded, go to R_DATA.
    - Latency: rvalid is high the cycle after the AR handshake.
  - R_DATA: hold rdata, rresp and rvalid stable until rready. Then rvalid<=0, arready<=1, go to R_IDLE.
- Simultaneous read and write to the same register: the read captures the pre-write value. A read accepted after bvalid is seen returns the new value.
- Back-to-back transactions: minimum 1 idle cycle between transactions on each channel, because readies re-assert the cycle after the response handshake.
- Reset mid-operation: any FSM returns to its IDLE state immediately. Pending responses are dropped, and register contents return to 0.
- Protocol compliance: valid outputs never depend combinationally on ready inputs.

Optional Feature:
- Macro: AXIL_SLV_ID_REG_EN.
- Defined:
  - Register 0 is read-only and reads ID_VALUE with OKAY.
  - A write to index 0 returns SLVERR, changes nothing and produces no reg_wr_pulse.
- Undefined: register 0 is an ordinary read/write register, and ID_VALUE is unused.

Test Plan:
- Full write then read (BASE_ADDR=0): write 0xDEADBEEF to 0x4 with awvalid and wvalid together -> bresp=00, reg_wr_pulse with idx=1. Read 0x4 -> rdata=0xDEADBEEF, rresp=00, rvalid 1 cycle after AR.
- Decoupled AW/W: AW at 0x8 in cycle n, W=0x12345678 in cycle n+3 -> bvalid only after the W handshake. Readback is 0x12345678.
- Byte strobes: write 0xFFFFFFFF to 0xC, then 0xAABBCCDD with wstrb=4'b0101 -> reads 0xFFBBFFDD.
- Decode error (BASE_ADDR=0x1000, NUM_REGS=16): write to 0x1040 and 0x2004 -> bresp=10 with no pulse. Read 0x1040 -> rdata=0, rresp=10. Read 0x1004 -> OKAY.
- Backpressure and reset: hold bready=0 and rready=0 for 5 cycles -> bvalid, bresp, rvalid and rdata stay stable, and awready/arready stay 0. Assert reset mid-R_DATA -> rvalid=0 immediately, and all registers read 0 after release.
- AXIL_SLV_ID_REG_EN defined: read 0x0 -> 0xA11E0001. Write 0x5 to 0x0 -> bresp=10, and a re-read still returns 0xA11E0001.
